// File: rtl/ahb_sram_ctrl.sv
// AHB-Lite slave bridging to a single-port synchronous SRAM, zero wait states.
// Optional ERROR responses for oversize/misaligned transfers: define AHB_SRAM_ERR_EN.
module ahb_sram_ctrl #(
    parameter int SZ = 64,
    parameter int AW = 10
) (
    input  logic            HCLK,
    input  logic            HRESETn,
    input  logic            HSEL,
    input  logic [31:0]     HADDR,
    input  logic [1:0]      HTRANS,
    input  logic            HWRITE,
    input  logic [2:0]      HSIZE,
    input  logic [SZ-1:0]   HWDATA,
    input  logic            HREADY,
    output logic            HREADYOUT,
    output logic            HRESP,
    output logic [SZ-1:0]   HRDATA,
    output logic            SRAM_EN,
    output logic [SZ/8-1:0] SRAM_WE,
    output logic [AW-1:0]   SRAM_A,
    output logic [SZ-1:0]   SRAM_DI,
    input  logic [SZ-1:0]   SRAM_DO
);

    localparam int NB = SZ / 8;
    localparam int L  = $clog2(NB);

    typedef enum logic [1:0] {OKAY, ERR1, ERR2} st_t;

    st_t             st_q, st_d;
    logic            dp_valid_q, dp_valid_d;
    logic            dp_write_q, dp_write_d;
    logic [AW-1:0]   dp_addr_q, dp_addr_d;
    logic [NB-1:0]   dp_mask_q, dp_mask_d;
    logic            wb_valid_q, wb_valid_d;
    logic [AW-1:0]   wb_addr_q, wb_addr_d;
    logic [NB-1:0]   wb_mask_q, wb_mask_d;
    logic [SZ-1:0]   wb_data_q, wb_data_d;

    logic            accept, err_req, rd_acc, wr_dp, drain, fwd;
    logic [2:0]      sz_eff;
    logic [L-1:0]    sz_lo, off;
    logic [NB-1:0]   amask;
    logic [AW-1:0]   haddr_w;
    logic            unused_bits;

    assign haddr_w     = HADDR[AW+L-1:L];
    assign unused_bits = ^{HTRANS[0], HADDR[31:AW+L]};

    assign accept = HRESETn & HSEL & HTRANS[1] & HREADY;
`ifdef AHB_SRAM_ERR_EN
    assign err_req = accept & ((HSIZE > 3'(L)) | (|(HADDR[L-1:0] & sz_lo)));
`else
    assign err_req = 1'b0;
`endif
    assign rd_acc = accept & ~HWRITE & ~err_req;
    assign wr_dp  = dp_valid_q & dp_write_q;
    assign drain  = wb_valid_q & ~rd_acc & ~wr_dp;
    assign fwd    = dp_valid_q & ~dp_write_q & wb_valid_q
                  & (wb_addr_q == dp_addr_q);

    // Lane mask: oversize clamps to full width, low bits aligned down to size
    always_comb begin
        sz_eff = (HSIZE > 3'(L)) ? 3'(L) : HSIZE;
        sz_lo  = L'((1 << sz_eff) - 1);
        off    = HADDR[L-1:0] & ~sz_lo;
        amask  = NB'((1 << (1 << sz_eff)) - 1) << off;
    end

    // Data-phase capture and write-buffer load/drain
    always_comb begin
        dp_valid_d = accept & ~err_req;
        dp_write_d = HWRITE;
        dp_addr_d  = haddr_w;
        dp_mask_d  = amask;
        wb_valid_d = wb_valid_q;
        wb_addr_d  = wb_addr_q;
        wb_mask_d  = wb_mask_q;
        wb_data_d  = wb_data_q;
        if (wr_dp && rd_acc) begin
            wb_valid_d = 1'b1;
            wb_addr_d  = dp_addr_q;
            wb_mask_d  = dp_mask_q;
            wb_data_d  = HWDATA;
        end else if (drain) begin
            wb_valid_d = 1'b0;
        end
    end

    // State registers; only the valid flags and FSM need reset
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            st_q       <= OKAY;
            dp_valid_q <= 1'b0;
            wb_valid_q <= 1'b0;
        end else begin
            st_q       <= st_d;
            dp_valid_q <= dp_valid_d;
            wb_valid_q <= wb_valid_d;
        end
        dp_write_q <= dp_write_d;
        dp_addr_q  <= dp_addr_d;
        dp_mask_q  <= dp_mask_d;
        wb_addr_q  <= wb_addr_d;
        wb_mask_q  <= wb_mask_d;
        wb_data_q  <= wb_data_d;
    end

    // Error FSM next state: two-cycle ERROR response
    always_comb begin
        st_d = st_q;
        unique case (st_q)
            OKAY:    st_d = err_req ? ERR1 : OKAY;
            ERR1:    st_d = ERR2;
            ERR2:    st_d = err_req ? ERR1 : OKAY;
            default: st_d = OKAY;
        endcase
    end

    // Error FSM outputs
    always_comb begin
        HREADYOUT = 1'b1;
        HRESP     = 1'b0;
        if (HRESETn) begin
            unique case (st_q)
                ERR1: begin
                    HREADYOUT = 1'b0;
                    HRESP     = 1'b1;
                end
                ERR2:    HRESP = 1'b1;
                default: ;
            endcase
        end
    end

    // SRAM port arbitration: read accept > write data phase > drain
    always_comb begin
        SRAM_EN = 1'b0;
        SRAM_WE = '0;
        SRAM_A  = haddr_w;
        SRAM_DI = HWDATA;
        if (HRESETn) begin
            if (rd_acc) begin
                SRAM_EN = 1'b1;
            end else if (wr_dp) begin
                SRAM_EN = 1'b1;
                SRAM_WE = dp_mask_q;
                SRAM_A  = dp_addr_q;
            end else if (wb_valid_q) begin
                SRAM_EN = 1'b1;
                SRAM_WE = wb_mask_q;
                SRAM_A  = wb_addr_q;
                SRAM_DI = wb_data_q;
            end
        end
    end

    // Read data with per-lane forwarding from the pending buffered write
    always_comb begin
        for (int i = 0; i < NB; i++) begin
            HRDATA[8*i +: 8] = (fwd && wb_mask_q[i]) ? wb_data_q[8*i +: 8]
                                                     : SRAM_DO[8*i +: 8];
        end
    end

`ifndef SYNTHESIS
    wb_empty_on_write: assert property (@(posedge HCLK) disable iff (!HRESETn)
        !(wr_dp && wb_valid_q));
`endif

endmodule

// File: tb/tb_ahb_sram_ctrl.sv
// Scoreboard bench for ahb_sram_ctrl (SZ=64, AW=10) with a behavioural SRAM.
// Error-response checks are built when AHB_SRAM_ERR_EN is defined.
module tb_ahb_sram_ctrl;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [63:0] HWDATA;
    logic        HREADY;
    logic        HREADYOUT;
    logic        HRESP;
    logic [63:0] HRDATA;
    logic        SRAM_EN;
    logic [7:0]  SRAM_WE;
    logic [9:0]  SRAM_A;
    logic [63:0] SRAM_DI;
    logic [63:0] SRAM_DO;

    logic        hready_m;
    logic [63:0] mem [0:1023];
    logic [63:0] ref_mem [0:1023];
    logic [63:0] sb [$];
    logic [63:0] nxt_wd;
    bit          prev_rd;
    int          n_vec;
    int          n_err;

    logic        obs_en, obs_rdy, obs_resp;
    logic [7:0]  obs_we;
    logic [9:0]  obs_a;
    logic [63:0] obs_rd;

    assign HREADY = hready_m & HREADYOUT;

    ahb_sram_ctrl #(.SZ(64), .AW(10)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR),
        .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA),
        .HREADY(HREADY), .HREADYOUT(HREADYOUT), .HRESP(HRESP),
        .HRDATA(HRDATA), .SRAM_EN(SRAM_EN), .SRAM_WE(SRAM_WE),
        .SRAM_A(SRAM_A), .SRAM_DI(SRAM_DI), .SRAM_DO(SRAM_DO)
    );

    always #5 HCLK = ~HCLK;

    always @(posedge HCLK) begin
        if (SRAM_EN) begin
            if (SRAM_WE == 8'h00) begin
                SRAM_DO <= mem[SRAM_A];
            end else begin
                for (int i = 0; i < 8; i++)
                    if (SRAM_WE[i]) mem[SRAM_A][8*i +: 8] <= SRAM_DI[8*i +: 8];
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] lanes(input logic [31:0] a,
                                         input logic [2:0] s);
        int n;
        int b;
        n = 1 << ((s > 3'd3) ? 3 : int'(s));
        b = (int'(a[2:0]) / n) * n;
        lanes = 8'h00;
        for (int i = 0; i < n; i++) lanes[b+i] = 1'b1;
    endfunction

    task automatic cyc(input bit sel, input bit nseq, input bit wr,
                       input logic [31:0] addr, input logic [2:0] sz,
                       input logic [63:0] wd);
        bit          acc;
        logic [7:0]  m;
        int          w;
        logic [63:0] exp;
        HSEL   = sel;
        HTRANS = nseq ? 2'b10 : 2'b00;
        HWRITE = wr;
        HADDR  = addr;
        HSIZE  = sz;
        HWDATA = nxt_wd;
        acc = HRESETn & sel & nseq & hready_m;
`ifdef AHB_SRAM_ERR_EN
        if (sz > 3'd3 || (addr[2:0] & 3'((1 << sz) - 1)) != 3'd0) acc = 1'b0;
`endif
        w = int'(addr[12:3]);
        if (acc && wr) begin
            m = lanes(addr, sz);
            for (int i = 0; i < 8; i++)
                if (m[i]) ref_mem[w][8*i +: 8] = wd[8*i +: 8];
            nxt_wd = wd;
        end
        if (acc && !wr) sb.push_back(ref_mem[w]);
        @(negedge HCLK);
        obs_en   = SRAM_EN;
        obs_we   = SRAM_WE;
        obs_a    = SRAM_A;
        obs_rd   = HRDATA;
        obs_rdy  = HREADYOUT;
        obs_resp = HRESP;
        if (!HRESETn) begin
            sb.delete();
            prev_rd = 1'b0;
        end
        if (prev_rd) begin
            if (sb.size() == 0) begin
                chk("sb_empty", 64'd1, 64'd0);
            end else begin
                exp = sb.pop_front();
                chk("rdata", HRDATA, exp);
            end
        end
`ifndef AHB_SRAM_ERR_EN
        chk("hresp", {63'd0, HRESP}, 64'd0);
        chk("hreadyout", {63'd0, HREADYOUT}, 64'd1);
`endif
        prev_rd = acc & !wr;
        @(posedge HCLK);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [2:0] s,
                      input logic [63:0] d);
        cyc(1'b1, 1'b1, 1'b1, a, s, d);
    endtask

    task automatic rd(input logic [31:0] a);
        cyc(1'b1, 1'b1, 1'b0, a, 3'd3, 64'd0);
    endtask

    task automatic idle();
        cyc(1'b1, 1'b0, 1'b0, 32'd0, 3'd0, 64'd0);
    endtask

    initial begin
        logic [63:0] saved;
        logic [63:0] d;
        int          k;
        int          sz;
        n_vec    = 0;
        n_err    = 0;
        prev_rd  = 1'b0;
        nxt_wd   = 64'd0;
        hready_m = 1'b1;
        HRESETn  = 1'b0;
        HSEL = 0; HTRANS = 0; HWRITE = 0; HADDR = 0; HSIZE = 0; HWDATA = 0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = 64'd0;

        repeat (2) begin
            idle();
            chk("rst_rdy", {63'd0, obs_rdy}, 64'd1);
            chk("rst_resp", {63'd0, obs_resp}, 64'd0);
            chk("rst_en", {63'd0, obs_en}, 64'd0);
            chk("rst_we", {56'd0, obs_we}, 64'd0);
        end
        HRESETn = 1'b1;

        for (int i = 0; i < 32; i++) wr(32'(i * 8), 3'd3, {$urandom, $urandom});
        wr(32'h200, 3'd3, 64'h0102030405060708);
        wr(32'h300, 3'd3, 64'hAAAA_AAAA_AAAA_AAAA);
        wr(32'h308, 3'd3, 64'h3080_3080_3080_3080);
        wr(32'h310, 3'd3, 64'h3100_3100_3100_3100);
        wr(32'h500, 3'd3, 64'h5005_5005_5005_5005);
        idle();

        wr(32'h100, 3'd3, 64'h1122334455667788);
        idle();
        chk("w100_we", {56'd0, obs_we}, 64'hFF);
        chk("w100_a", {54'd0, obs_a}, 64'h20);
        rd(32'h100);
        chk("r100_en", {63'd0, obs_en}, 64'd1);
        chk("r100_we", {56'd0, obs_we}, 64'd0);
        idle();
        chk("r100_data", obs_rd, 64'h1122334455667788);

        wr(32'h203, 3'd0, 64'hAB << 24);
        rd(32'h200);
        chk("r200_we", {56'd0, obs_we}, 64'd0);
        chk("r200_a", {54'd0, obs_a}, 64'h40);
        idle();
        chk("fwd_b3", {56'd0, obs_rd[31:24]}, 64'hAB);
        chk("drain_we", {56'd0, obs_we}, 64'h08);
        chk("drain_a", {54'd0, obs_a}, 64'h40);

        d = 64'hDEAD_BEEF_0BAD_F00D;
        wr(32'h300, 3'd3, d);
        rd(32'h308);
        chk("hold1_we", {56'd0, obs_we}, 64'd0);
        rd(32'h310);
        chk("hold2_we", {56'd0, obs_we}, 64'd0);
        rd(32'h300);
        chk("hold3_we", {56'd0, obs_we}, 64'd0);
        idle();
        chk("fwd300", obs_rd, d);
        chk("drain300_we", {56'd0, obs_we}, 64'hFF);
        chk("drain300_a", {54'd0, obs_a}, 64'h60);
        rd(32'h300);
        idle();

        cyc(1'b0, 1'b1, 1'b1, 32'h100, 3'd3, 64'h0);
        chk("nosel_en", {63'd0, obs_en}, 64'd0);
        idle();
        chk("nosel_dp_en", {63'd0, obs_en}, 64'd0);
        hready_m = 1'b0;
        cyc(1'b1, 1'b1, 1'b1, 32'h100, 3'd3, 64'h0);
        chk("nordy_en", {63'd0, obs_en}, 64'd0);
        hready_m = 1'b1;
        idle();
        chk("nordy_dp_en", {63'd0, obs_en}, 64'd0);

        wr(32'h400, 3'd4, 64'h4444_5555_6666_7777);
`ifdef AHB_SRAM_ERR_EN
        idle();
        chk("err1_rdy", {63'd0, obs_rdy}, 64'd0);
        chk("err1_resp", {63'd0, obs_resp}, 64'd1);
        chk("err1_en", {63'd0, obs_en}, 64'd0);
        idle();
        chk("err2_rdy", {63'd0, obs_rdy}, 64'd1);
        chk("err2_resp", {63'd0, obs_resp}, 64'd1);
        chk("err2_en", {63'd0, obs_en}, 64'd0);
        idle();
        chk("errok_resp", {63'd0, obs_resp}, 64'd0);
        cyc(1'b1, 1'b1, 1'b0, 32'h401, 3'd1, 64'd0);
        chk("mis_en", {63'd0, obs_en}, 64'd0);
        idle();
        chk("mis_resp", {63'd0, obs_resp}, 64'd1);
        idle();
        idle();
`else
        idle();
        chk("big_we", {56'd0, obs_we}, 64'hFF);
        rd(32'h400);
        idle();
`endif

        saved = ref_mem[10'hA0];
        wr(32'h500, 3'd3, 64'hBAD0_BAD0_BAD0_BAD0);
        rd(32'h508);
        HRESETn = 1'b0;
        repeat (2) begin
            idle();
            chk("mrst_rdy", {63'd0, obs_rdy}, 64'd1);
            chk("mrst_resp", {63'd0, obs_resp}, 64'd0);
            chk("mrst_en", {63'd0, obs_en}, 64'd0);
        end
        HRESETn = 1'b1;
        ref_mem[10'hA0] = saved;
        rd(32'h500);
        idle();
        chk("lost_wr", obs_rd, saved);

        for (int n = 0; n < 400; n++) begin
            k  = $urandom_range(0, 3);
            sz = $urandom_range(0, 3);
            HADDR = {$urandom_range(0, 31), 3'b000};
            HADDR[2:0] = 3'($urandom_range(0, 7)) & ~3'((1 << sz) - 1);
            if (k == 0) idle();
            else if (k == 1) wr(HADDR, 3'(sz), {$urandom, $urandom});
            else rd(HADDR);
        end
        idle();
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
